// File: rtl/aram_slot_scheduler_pkg.sv
// Shared constants, owner encoding and slot helpers for the audio-RAM slot scheduler.
package aram_sched_pkg;

    localparam int N_VOICES       = 8;
    localparam int ADDR_W         = 16;
    localparam int VOICE_SLOT_LEN = 4;

    typedef enum logic [1:0] {
        OWN_CPU   = 2'd0,
        OWN_VOICE = 2'd1,
        OWN_ECHO  = 2'd2,
        OWN_SRC   = 2'd3
    } owner_e;

    localparam logic [5:0] VOICE_BASE  = 6'd62;
    localparam logic [5:0] ECHO_FIRST  = 6'd33;
    localparam logic [5:0] ECHO_LAST   = 6'd40;
    localparam logic [5:0] SRC_FIRST   = 6'd41;
    localparam logic [5:0] SRC_LAST    = 6'd46;
    localparam logic [5:0] SAMPLE_STEP = 6'd63;

    // Six-bit addition wraps modulo 64, so voice 0 starts at 62.
    function automatic logic [5:0] voice_start(input logic [2:0] v);
        return VOICE_BASE + {1'b0, v, 2'b00};
    endfunction

endpackage

// File: rtl/aram_slot_scheduler_if.sv
// CPU request/ack channel and the single audio-RAM port, bundled for the scheduler.
interface aram_slot_scheduler_if;

    // cpu_req is held with stable addr/we/wdata until cpu_ack pulses for one
    // cycle; cpu_rdata is valid with cpu_ack, and no new grant happens while ack is high.
    logic                            cpu_req;
    logic [aram_sched_pkg::ADDR_W-1:0] cpu_addr;
    logic                            cpu_we;
    logic [7:0]                      cpu_wdata;
    logic                            cpu_ack;
    logic [7:0]                      cpu_rdata;

    logic [aram_sched_pkg::ADDR_W-1:0] ram_address;
    logic [7:0]                      ram_wdata;
    logic                            ram_write_enable;
    logic [7:0]                      ram_data;

    modport master (
        output cpu_req, cpu_addr, cpu_we, cpu_wdata, ram_data,
        input  cpu_ack, cpu_rdata, ram_address, ram_wdata, ram_write_enable
    );

    modport slave (
        input  cpu_req, cpu_addr, cpu_we, cpu_wdata, ram_data,
        output cpu_ack, cpu_rdata, ram_address, ram_wdata, ram_write_enable
    );

endinterface

// File: rtl/aram_slot_scheduler_decode.sv
// Combinational map from schedule step to RAM owner and voice index.
module aram_slot_decode
    import aram_sched_pkg::*;
(
    input  logic [5:0]          step,
    input  logic [N_VOICES-1:0] voice_active,
    input  logic                enable,
    output owner_e              owner,
    output logic [2:0]          voice
);

    logic [5:0] rel;
    logic       in_voice;

    always_comb begin
        // Rotate so voice slots occupy 0..31; voice index is then rel/4.
        rel      = step - VOICE_BASE;
        in_voice = (rel[5] == 1'b0);
        voice    = in_voice ? rel[4:2] : 3'd0;
        owner    = OWN_CPU;
        if (!enable) begin
            owner = OWN_CPU;
        end else if (in_voice) begin
            owner = voice_active[rel[4:2]] ? OWN_VOICE : OWN_CPU;
        end else if (step >= ECHO_FIRST && step <= ECHO_LAST) begin
            owner = OWN_ECHO;
        end else if (step >= SRC_FIRST && step <= SRC_LAST) begin
            owner = OWN_SRC;
        end
    end

endmodule

// File: rtl/aram_slot_scheduler.sv
// 64-step per-sample schedule and time-multiplexed audio-RAM port for the S-DSP.
module aram_slot_scheduler
    import aram_sched_pkg::*;
(
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [N_VOICES-1:0]        voice_active,
    input  logic [N_VOICES*ADDR_W-1:0] voice_addr,
    input  logic [ADDR_W-1:0]          echo_addr,
    input  logic                       echo_we,
    input  logic [7:0]                 echo_wdata,
    input  logic [ADDR_W-1:0]          src_addr,
    aram_slot_scheduler_if.slave       bus,
    output logic [5:0]                 major_step,
    output logic [1:0]                 owner,
    output logic [2:0]                 current_voice,
    output logic [N_VOICES-1:0]        voice_advance,
    output logic [2:0]                 src_voice,
    output logic                       sample_strobe
);

    logic [5:0]          step_q, step_d;
    logic [2:0]          src_voice_q, src_voice_d;
    logic                started_q, started_d;
    logic [N_VOICES-1:0] adv_q, adv_d;
    logic                strobe_q, strobe_d;
    logic                ack_q, ack_d;
    logic [7:0]          rdata_q, rdata_d;

    owner_e     slot_owner;
    logic [2:0] slot_voice;
    logic       grant;

    // Until the first enabled edge the schedule has not begun, so the CPU owns the port.
    aram_slot_decode u_decode (
        .step         (step_q),
        .voice_active (voice_active),
        .enable       (enable & started_q),
        .owner        (slot_owner),
        .voice        (slot_voice)
    );

    always_comb begin
        grant = reset && (slot_owner == OWN_CPU) && bus.cpu_req && !ack_q;
        bus.ram_address      = '0;
        bus.ram_wdata        = '0;
        bus.ram_write_enable = 1'b0;
        case (slot_owner)
            OWN_VOICE: bus.ram_address = voice_addr[{slot_voice, 4'b0000} +: ADDR_W];
            OWN_ECHO: begin
                bus.ram_address      = echo_addr;
                bus.ram_wdata        = echo_wdata;
                bus.ram_write_enable = echo_we;
            end
            OWN_SRC: bus.ram_address = src_addr;
            default: begin
                if (grant) begin
                    bus.ram_address      = bus.cpu_addr;
                    bus.ram_wdata        = bus.cpu_wdata;
                    bus.ram_write_enable = bus.cpu_we;
                end
            end
        endcase
    end

    always_comb begin
        step_d      = enable ? step_q + 6'd1 : step_q;
        started_d   = started_q | enable;
        src_voice_d = (enable && started_q && step_q == SAMPLE_STEP) ? src_voice_q + 3'd1
                                                                     : src_voice_q;
        for (int v = 0; v < N_VOICES; v++) begin
            adv_d[v] = enable && (step_d == voice_start(3'(v)));
        end
        strobe_d = enable && (step_d == SAMPLE_STEP);
        ack_d    = grant;
        rdata_d  = (grant && !bus.cpu_we) ? bus.ram_data : rdata_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            step_q      <= SAMPLE_STEP;
            src_voice_q <= 3'd0;
            started_q   <= 1'b0;
            adv_q       <= '0;
            strobe_q    <= 1'b0;
            ack_q       <= 1'b0;
            rdata_q     <= 8'd0;
        end else begin
            step_q      <= step_d;
            src_voice_q <= src_voice_d;
            started_q   <= started_d;
            adv_q       <= adv_d;
            strobe_q    <= strobe_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
        end
    end

    assign major_step    = step_q;
    assign owner         = slot_owner;
    assign current_voice = slot_voice;
    assign voice_advance = adv_q & {N_VOICES{enable}};
    assign sample_strobe = strobe_q & enable;
    assign src_voice     = src_voice_q;
    assign bus.cpu_ack   = ack_q;
    assign bus.cpu_rdata = rdata_q;

endmodule

// File: tb/tb_aram_slot_scheduler.sv
// Directed-plus-random bench for aram_slot_scheduler against a slot-table reference model.
module tb_aram_slot_scheduler;

    logic         clock = 1'b0;
    logic         reset;
    logic         enable;
    logic [7:0]   voice_active;
    logic [127:0] voice_addr;
    logic [15:0]  echo_addr;
    logic         echo_we;
    logic [7:0]   echo_wdata;
    logic [15:0]  src_addr;
    logic [5:0]   major_step;
    logic [1:0]   owner;
    logic [2:0]   current_voice;
    logic [7:0]   voice_advance;
    logic [2:0]   src_voice;
    logic         sample_strobe;

    aram_slot_scheduler_if bus ();

    aram_slot_scheduler dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .voice_active  (voice_active),
        .voice_addr    (voice_addr),
        .echo_addr     (echo_addr),
        .echo_we       (echo_we),
        .echo_wdata    (echo_wdata),
        .src_addr      (src_addr),
        .bus           (bus),
        .major_step    (major_step),
        .owner         (owner),
        .current_voice (current_voice),
        .voice_advance (voice_advance),
        .src_voice     (src_voice),
        .sample_strobe (sample_strobe)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: slot table built from the ownership rules, plus sequencing state.
    int         slot_kind [64];
    int         slot_voice[64];
    int         m_step, m_src;
    bit         m_started, m_last_en, m_ack;
    logic [7:0] m_rdata;

    task automatic init_table();
        for (int s = 0; s < 64; s++) begin
            slot_kind[s]  = 0;
            slot_voice[s] = 0;
        end
        for (int v = 0; v < 8; v++)
            for (int k = 0; k < 4; k++) begin
                slot_kind[(62 + 4 * v + k) % 64]  = 1;
                slot_voice[(62 + 4 * v + k) % 64] = v;
            end
        for (int s = 33; s <= 40; s++) slot_kind[s] = 2;
        for (int s = 41; s <= 46; s++) slot_kind[s] = 3;
    endtask

    task automatic model_reset();
        m_step = 63; m_src = 0; m_started = 0; m_last_en = 0; m_ack = 0; m_rdata = 8'd0;
    endtask

    function automatic int exp_owner();
        if (!(enable && m_started)) return 0;
        if (slot_kind[m_step] == 1 && !voice_active[slot_voice[m_step]]) return 0;
        return slot_kind[m_step];
    endfunction

    function automatic bit exp_grant();
        return reset && (exp_owner() == 0) && bus.cpu_req && !m_ack;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (model step %0d)", tag, obs, exp, m_step);
        end
    endtask

    task automatic check_all();
        int         own;
        bit         grant;
        logic [15:0] e_addr;
        logic        e_we;
        logic [7:0]  e_wd;
        bit          chk_wd;
        logic [7:0]  e_adv;
        own = exp_owner();
        grant = exp_grant();
        e_addr = 16'd0; e_we = 1'b0; e_wd = 8'd0; chk_wd = 0;
        case (own)
            1: e_addr = voice_addr[slot_voice[m_step] * 16 +: 16];
            2: begin e_addr = echo_addr; e_we = echo_we; e_wd = echo_wdata; chk_wd = 1; end
            3: e_addr = src_addr;
            default: if (grant) begin
                e_addr = bus.cpu_addr; e_we = bus.cpu_we; e_wd = bus.cpu_wdata; chk_wd = bus.cpu_we;
            end
        endcase
        for (int v = 0; v < 8; v++)
            e_adv[v] = enable && m_last_en && (m_step == (62 + 4 * v) % 64);
        chk("major_step", major_step, m_step);
        chk("owner", owner, own);
        if (slot_kind[m_step] == 1) chk("current_voice", current_voice, slot_voice[m_step]);
        chk("voice_advance", voice_advance, e_adv);
        chk("sample_strobe", sample_strobe, enable && m_last_en && m_step == 63);
        chk("src_voice", src_voice, m_src);
        chk("cpu_ack", bus.cpu_ack, m_ack);
        chk("cpu_rdata", bus.cpu_rdata, m_rdata);
        chk("ram_address", bus.ram_address, e_addr);
        chk("ram_write_enable", bus.ram_write_enable, e_we);
        if (chk_wd) chk("ram_wdata", bus.ram_wdata, e_wd);
    endtask

    task automatic model_edge();
        bit grant;
        grant = exp_grant();
        if (grant && !bus.cpu_we) m_rdata = bus.ram_data;
        if (enable) begin
            if (m_step == 63 && m_started) m_src = (m_src + 1) % 8;
            m_step    = (m_step + 1) % 64;
            m_started = 1;
        end
        m_last_en = enable;
        m_ack     = grant;
    endtask

    // Inputs are set just after a rising edge; check, advance the model, take the edge.
    task automatic cycle();
        #1;
        check_all();
        model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic randomize_bg(input bit keep_ram_data);
        for (int v = 0; v < 8; v++) voice_addr[v * 16 +: 16] = 16'($urandom);
        echo_addr  = 16'($urandom);
        echo_we    = 1'($urandom);
        echo_wdata = 8'($urandom);
        src_addr   = 16'($urandom);
        if (!keep_ram_data) bus.ram_data = 8'($urandom);
    endtask

    task automatic new_req();
        bus.cpu_addr  = 16'($urandom);
        bus.cpu_we    = 1'($urandom);
        bus.cpu_wdata = 8'($urandom);
    endtask

    task automatic run_to(input int target);
        for (int i = 0; i < 70 && m_step != target; i++) begin
            randomize_bg(0);
            cycle();
        end
        chk("run_to", major_step, target);
    endtask

    initial begin
        init_table();
        model_reset();
        reset = 1'b0; enable = 1'b1; voice_active = 8'hFF;
        voice_addr = '0; echo_addr = '0; echo_we = 1'b0; echo_wdata = '0; src_addr = '0;
        bus.cpu_req = 1'b0; bus.cpu_addr = '0; bus.cpu_we = 1'b0; bus.cpu_wdata = '0;
        bus.ram_data = '0;
        @(posedge clock);
        #1;
        randomize_bg(0);
        #1;
        check_all();
        reset = 1'b1;

        // Free run: advance pulses, strobe and src_voice over two samples.
        for (int i = 0; i < 130; i++) begin
            randomize_bg(0);
            cycle();
        end

        // CPU read in a free slot, request kept high through the ack cycle.
        run_to(50);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h1234;
        bus.ram_data = 8'hA5;
        cycle();
        chk("rd_ack", bus.cpu_ack, 1'b1);
        chk("rd_data", bus.cpu_rdata, 8'hA5);
        bus.ram_data = 8'h3C;
        cycle();
        bus.cpu_req = 1'b0;
        cycle();

        // CPU write from inside the voice slots waits for step 30.
        run_to(3);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'hBEEF; bus.cpu_wdata = 8'h5A;
        for (int i = 0; i < 64 && !m_ack; i++) begin
            randomize_bg(0);
            cycle();
        end
        chk("wr_ack", bus.cpu_ack, 1'b1);
        chk("wr_ack_step", major_step, 6'd31);
        bus.cpu_req = 1'b0;
        cycle();

        // Donated voice-2 slot grants immediately.
        run_to(7);
        voice_active = 8'hFB;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0777;
        cycle();
        chk("donate_ack", bus.cpu_ack, 1'b1);
        bus.cpu_req = 1'b0;
        cycle();
        voice_active = 8'hFF;

        // Pause mid-sample and resume.
        run_to(36);
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            randomize_bg(0);
            cycle();
        end
        chk("pause_hold", major_step, 6'd36);
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            randomize_bg(0);
            cycle();
        end

        // Random traffic with the request held until acknowledged.
        for (int i = 0; i < 600; i++) begin
            randomize_bg(0);
            enable = ($urandom_range(0, 7) != 0);
            voice_active = 8'($urandom);
            if (bus.cpu_req && m_ack) begin
                bus.cpu_req = 1'($urandom_range(0, 1));
                new_req();
            end else if (!bus.cpu_req && $urandom_range(0, 3) == 0) begin
                bus.cpu_req = 1'b1;
                new_req();
            end
            cycle();
        end

        // Reset arriving while a request waits in a voice slot.
        bus.cpu_req = 1'b0;
        enable = 1'b1; voice_active = 8'hFF;
        run_to(10);
        bus.cpu_req = 1'b1; new_req();
        #1;
        reset = 1'b0;
        model_reset();
        #1;
        check_all();
        reset = 1'b1;
        for (int i = 0; i < 70; i++) begin
            randomize_bg(0);
            if (bus.cpu_req && m_ack) bus.cpu_req = 1'b0;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
